// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI write or read out, one response back.
// A cycle timeout answers for a silent slave, then drains the late handshakes before the next command.
module axi_lite_cmd_master #(
   parameter int unsigned P_ADDR_WIDTH     = 32,
   parameter int unsigned P_DATA_WIDTH     = 32,
   parameter int unsigned P_TIMEOUT_CYCLES = 1024
) (
   input  logic                      ACLK,
   input  logic                      ARESETn,
   // command stream
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [P_ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [P_DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [P_DATA_WIDTH/8-1:0] cmd_wstrb,
   // response stream
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic                      rsp_write,
   output logic [P_DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]                rsp_resp,
   output logic                      rsp_timeout,
   // AXI4-Lite master
   output logic [P_ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [2:0]                m_axi_awprot,
   output logic                      m_axi_awvalid,
   input  logic                      m_axi_awready,
   output logic [P_DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [P_DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                      m_axi_wvalid,
   input  logic                      m_axi_wready,
   input  logic [1:0]                m_axi_bresp,
   input  logic                      m_axi_bvalid,
   output logic                      m_axi_bready,
   output logic [P_ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [2:0]                m_axi_arprot,
   output logic                      m_axi_arvalid,
   input  logic                      m_axi_arready,
   input  logic [P_DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]                m_axi_rresp,
   input  logic                      m_axi_rvalid,
   output logic                      m_axi_rready
);

   localparam int unsigned CNT_W = (P_TIMEOUT_CYCLES == 0) ? 1 : $clog2(P_TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {StIdle, StWr, StWrB, StRdAr, StRdR, StRsp, StDrain} state_e;

   state_e           state;
   logic             cmd_write_q;
   logic             aw_done;
   logic             w_done;
   logic             xfer_done;
   logic [CNT_W-1:0] tmo_cnt;

   logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
   logic aw_fin, w_fin, busy, tmo_hit, tmo_fire;

   assign m_axi_awprot = 3'b000;
   assign m_axi_arprot = 3'b000;

   assign aw_hs  = m_axi_awvalid & m_axi_awready;
   assign w_hs   = m_axi_wvalid & m_axi_wready;
   assign ar_hs  = m_axi_arvalid & m_axi_arready;
   assign b_hs   = m_axi_bvalid & m_axi_bready;
   assign r_hs   = m_axi_rvalid & m_axi_rready;
   assign aw_fin = aw_done | aw_hs;
   assign w_fin  = w_done | w_hs;

   assign busy    = (state == StWr) || (state == StWrB) || (state == StRdAr) || (state == StRdR);
   // Fires on the edge that ends the P_TIMEOUT_CYCLES-th busy cycle.
   assign tmo_hit = (P_TIMEOUT_CYCLES != 0) &&
                    ((32'(tmo_cnt) + 32'd1) == P_TIMEOUT_CYCLES);
   // A real B/R arriving on the timeout edge wins over the timeout.
   assign tmo_fire = busy && tmo_hit && !((state == StWrB) && b_hs) &&
                     !((state == StRdR) && r_hs);

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state         <= StIdle;
         cmd_write_q   <= 1'b0;
         aw_done       <= 1'b0;
         w_done        <= 1'b0;
         xfer_done     <= 1'b0;
         tmo_cnt       <= '0;
         cmd_ready     <= 1'b1;
         rsp_valid     <= 1'b0;
         rsp_write     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_resp      <= 2'b00;
         rsp_timeout   <= 1'b0;
         m_axi_awaddr  <= '0;
         m_axi_awvalid <= 1'b0;
         m_axi_wdata   <= '0;
         m_axi_wstrb   <= '0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axi_araddr  <= '0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
      end else begin
         // Address/data channels retire on their own handshake in every state, DRAIN included.
         if (aw_hs) begin
            m_axi_awvalid <= 1'b0;
            aw_done       <= 1'b1;
         end
         if (w_hs) begin
            m_axi_wvalid <= 1'b0;
            w_done       <= 1'b1;
         end
         if (ar_hs) m_axi_arvalid <= 1'b0;

         if (busy && (tmo_cnt != '1)) tmo_cnt <= tmo_cnt + CNT_W'(1);

         case (state)
            StIdle: begin
               if (cmd_valid) begin
                  cmd_ready   <= 1'b0;
                  cmd_write_q <= cmd_write;
                  tmo_cnt     <= '0;
                  aw_done     <= 1'b0;
                  w_done      <= 1'b0;
                  xfer_done   <= 1'b0;
                  if (cmd_write) begin
                     m_axi_awaddr  <= cmd_addr;
                     m_axi_wdata   <= cmd_wdata;
                     m_axi_wstrb   <= cmd_wstrb;
                     m_axi_awvalid <= 1'b1;
                     m_axi_wvalid  <= 1'b1;
                     state         <= StWr;
                  end else begin
                     m_axi_araddr  <= cmd_addr;
                     m_axi_arvalid <= 1'b1;
                     state         <= StRdAr;
                  end
               end
            end
            StWr: begin
               if (aw_fin && w_fin) begin
                  m_axi_bready <= 1'b1;
                  state        <= StWrB;
               end
            end
            StWrB: begin
               if (b_hs) begin
                  m_axi_bready <= 1'b0;
                  rsp_valid    <= 1'b1;
                  rsp_write    <= 1'b1;
                  rsp_rdata    <= '0;
                  rsp_resp     <= m_axi_bresp;
                  rsp_timeout  <= 1'b0;
                  state        <= StRsp;
               end
            end
            StRdAr: begin
               if (ar_hs) begin
                  m_axi_rready <= 1'b1;
                  state        <= StRdR;
               end
            end
            StRdR: begin
               if (r_hs) begin
                  m_axi_rready <= 1'b0;
                  rsp_valid    <= 1'b1;
                  rsp_write    <= 1'b0;
                  rsp_rdata    <= m_axi_rdata;
                  rsp_resp     <= m_axi_rresp;
                  rsp_timeout  <= 1'b0;
                  state        <= StRsp;
               end
            end
            StRsp: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= StIdle;
               end
            end
            StDrain: begin
               if (b_hs) m_axi_bready <= 1'b0;
               if (r_hs) m_axi_rready <= 1'b0;
               if (b_hs || r_hs) xfer_done <= 1'b1;
               if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
               if ((xfer_done || b_hs || r_hs) && (!rsp_valid || rsp_ready)) begin
                  m_axi_bready <= 1'b0;
                  m_axi_rready <= 1'b0;
                  cmd_ready    <= 1'b1;
                  state        <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase

         // Timeout overrides the per-state updates above; late B/R are swallowed in DRAIN.
         if (tmo_fire) begin
            rsp_valid    <= 1'b1;
            rsp_write    <= cmd_write_q;
            rsp_rdata    <= '0;
            rsp_resp     <= 2'b10;
            rsp_timeout  <= 1'b1;
            m_axi_bready <= cmd_write_q;
            m_axi_rready <= !cmd_write_q;
            state        <= StDrain;
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master with a configurable AXI-Lite slave model
// whose register at 0x0 reads back the last written word (tx/rx loopback stand-in).
module tb_axi_lite_cmd_master;

   logic        ACLK = 1'b0;
   logic        ARESETn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [2:0]  awprot, arprot;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  bresp, rresp;

   always #5 ACLK = ~ACLK;

   axi_lite_cmd_master #(
      .P_ADDR_WIDTH(32), .P_DATA_WIDTH(32), .P_TIMEOUT_CYCLES(16)
   ) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
      .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
      .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
      .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
      .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_araddr(araddr),
      .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
      .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
   );

   // Slave configuration and model state
   int          aw_lat, w_lat;
   logic        ar_block, b_block;
   logic [1:0]  bresp_cfg;
   int          aw_wait, w_wait;
   logic        got_aw, got_w;
   logic [31:0] loop_reg, last_awaddr, last_wdata;
   logic [3:0]  last_wstrb;
   int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, rsp_cnt;
   int          checks, errors;

   assign awready = awvalid && (aw_wait >= aw_lat);
   assign wready  = wvalid && (w_wait >= w_lat);
   assign arready = arvalid && !ar_block;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         aw_wait <= 0; w_wait <= 0; got_aw <= 1'b0; got_w <= 1'b0;
         bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00;
      end else begin
         aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
         w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
         if (awvalid && awready) got_aw <= 1'b1;
         if (wvalid && wready) got_w <= 1'b1;
         if ((got_aw || (awvalid && awready)) && (got_w || (wvalid && wready)) &&
             !bvalid && !b_block) begin
            bvalid <= 1'b1; bresp <= bresp_cfg; got_aw <= 1'b0; got_w <= 1'b0;
         end
         if (bvalid && bready) bvalid <= 1'b0;
         if (arvalid && arready) begin
            rvalid <= 1'b1;
            rdata  <= (araddr == 32'h0) ? loop_reg : (32'hC0DE_0000 | araddr);
            rresp  <= 2'b00;
         end
         if (rvalid && rready) rvalid <= 1'b0;
      end
   end

   // Traffic counters survive reset so aborted transactions stay visible.
   always_ff @(posedge ACLK) begin
      if (ARESETn) begin
         if (awvalid && awready) begin aw_cnt <= aw_cnt + 1; last_awaddr <= awaddr; end
         if (wvalid && wready) begin
            w_cnt <= w_cnt + 1; last_wdata <= wdata; last_wstrb <= wstrb; loop_reg <= wdata;
         end
         if (bvalid && bready) b_cnt <= b_cnt + 1;
         if (arvalid && arready) ar_cnt <= ar_cnt + 1;
         if (rvalid && rready) r_cnt <= r_cnt + 1;
         if (rsp_valid && rsp_ready) rsp_cnt <= rsp_cnt + 1;
      end
   end

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a command and return once its handshake edge has passed (cycle N+1).
   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int waited);
      waited = 0;
      cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
      while (cmd_ready !== 1'b1 && waited < 40) begin
         tick();
         waited++;
      end
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      int waited;
      checks = 0; errors = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; rsp_cnt = 0;
      loop_reg = '0; last_awaddr = '0; last_wdata = '0; last_wstrb = '0;
      aw_lat = 0; w_lat = 0; ar_block = 1'b0; b_block = 1'b0; bresp_cfg = 2'b00;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
      rsp_ready = 1'b1;
      ARESETn = 1'b1;
      #2 ARESETn = 1'b0;
      tick(); tick();
      check("reset_ready_valids", {cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready},
            7'b1000000);
      check("reset_data", {awaddr, wdata}, 64'h0);
      check("reset_rsp", {rsp_rdata, rsp_resp, rsp_timeout, rsp_write, wstrb, araddr}, 64'h0);
      ARESETn = 1'b1;
      tick();

      // Write 6 to 0x4, zero-wait slave
      issue(1'b1, 32'h4, 32'h6, 4'hF, waited);
      check("wr_accept_wait", 64'(waited), 64'd0);
      check("wr_n1_valids", {awvalid, wvalid, cmd_ready, bready}, 4'b1100);
      check("wr_n1_payload", {awaddr, wdata}, {32'h4, 32'h6});
      check("wr_n1_strb_prot", {wstrb, awprot, arprot}, {4'hF, 6'b0});
      tick();
      check("wr_n2_bready", {awvalid, wvalid, bready}, 3'b001);
      tick();
      check("wr_n3_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_timeout, bready}, 6'b110000);
      check("wr_n3_rdata", 64'(rsp_rdata), 64'h0);
      tick();
      check("wr_n4_ready", {cmd_ready, rsp_valid}, 2'b10);
      check("wr_slave_seen", {64'(aw_cnt), 64'(w_cnt)} == {64'd1, 64'd1} ? 64'(last_awaddr) : 64'hX,
            64'h4);
      check("wr_slave_data", {last_wdata, 28'h0, last_wstrb}, {32'h6, 32'hF});

      // Read back 0x0 on the very next cycle (5-cycle spacing)
      issue(1'b0, 32'h0, 32'h0, 4'h0, waited);
      check("rd_accept_wait", 64'(waited), 64'd0);
      check("rd_n1", {arvalid, rready, 32'h0 | araddr}, {2'b10, 32'h0});
      tick();
      check("rd_n2", {arvalid, rready}, 2'b01);
      tick();
      check("rd_n3_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_timeout}, 5'b10000);
      check("rd_n3_rdata", 64'(rsp_rdata), 64'h6);
      tick();
      rsp_ready = 1'b0;
      check("rd_n4_ready", {cmd_ready, 64'(ar_cnt), 64'(r_cnt)}, {1'b1, 64'd1, 64'd1});

      // W accepted three cycles before AW, BRESP=01, response then stalled 10 cycles
      aw_lat = 3; bresp_cfg = 2'b01;
      issue(1'b1, 32'h8, 32'hA5, 4'h3, waited);
      check("skew_n1", {awvalid, wvalid}, 2'b11);
      tick();
      check("skew_n2", {awvalid, wvalid, bready}, 3'b100);
      tick(); tick();
      check("skew_n4", {awvalid, wvalid, bready}, 3'b100);
      tick();
      check("skew_n5", {awvalid, wvalid, bready, bvalid}, 4'b0011);
      tick();
      for (int i = 0; i < 10; i++) begin
         check("stall_hold", {rsp_valid, rsp_write, rsp_resp, rsp_timeout, cmd_ready, rsp_rdata},
               {6'b110100, 32'h0});
         tick();
      end
      check("skew_one_b", 64'(b_cnt), 64'd2);
      aw_lat = 0; bresp_cfg = 2'b00;
      ar_block = 1'b1;
      rsp_ready = 1'b1;
      tick();
      check("stall_release", {cmd_ready, rsp_valid}, 2'b10);

      // Read with AR never accepted: timeout at N+17, then drain
      issue(1'b0, 32'h8, 32'h0, 4'h0, waited);
      check("tmo_accept_wait", 64'(waited), 64'd0);
      repeat (15) tick();
      check("tmo_n16", {rsp_valid, arvalid}, 2'b01);
      tick();
      check("tmo_n17_rsp", {rsp_valid, rsp_timeout, rsp_resp, rsp_write, arvalid, cmd_ready},
            7'b1110010);
      check("tmo_n17_rdata", 64'(rsp_rdata), 64'h0);
      tick();
      check("drain_wait", {rsp_valid, cmd_ready, arvalid, rready}, 4'b0011);
      tick(); tick();
      check("drain_still", {cmd_ready, arvalid}, 2'b01);
      ar_block = 1'b0;
      tick();
      check("drain_ar_done", {arvalid, rvalid, rready, cmd_ready}, 4'b0110);
      tick();
      check("drain_idle", {cmd_ready, rready, rsp_valid}, 3'b100);
      check("drain_counts", {64'(rsp_cnt), 64'(r_cnt)}, {64'd4, 64'd2});

      // Reset pulsed while waiting for B
      b_block = 1'b1;
      issue(1'b1, 32'h10, 32'h1234, 4'hF, waited);
      tick();
      check("rst_in_wrb", {bready, awvalid, cmd_ready}, 3'b100);
      #2 ARESETn = 1'b0;
      #1;
      check("rst_async", {cmd_ready, bready, awvalid, wvalid, rsp_valid}, 5'b10000);
      check("rst_async_data", {awaddr, wdata}, 64'h0);
      tick();
      ARESETn = 1'b1;
      b_block = 1'b0;
      tick(); tick();
      check("rst_release", {cmd_ready, rsp_valid, bready}, 3'b100);
      check("rst_no_rsp", 64'(rsp_cnt), 64'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/axi_lite_cmd_master.md
# axi_lite_cmd_master

Single-outstanding AXI4-Lite master that turns a simple command/response valid-ready stream into AXI4-Lite write and read transactions. It sits directly upstream of the AXI-Lite UART slave and replaces hand-written handshake sequencing in controllers and benches. A controller issues one write or read command, and the block completes every AXI channel handshake. It then returns BRESP/RRESP and read data on the response port. A cycle timeout flags a slave that never responds.

## Interface
- P_ADDR_WIDTH, 32, AXI address width
- P_DATA_WIDTH, 32, AXI data width (32 or 64); strobe width is P_DATA_WIDTH/8
- P_TIMEOUT_CYCLES, 1024, cycles from issue to response before a timeout is reported; 0 disables the timeout
- ACLK  in  1  clock
- ARESETn  in  1  reset, asynchronous, active-low
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  P_ADDR_WIDTH  byte address
- cmd_wdata  in  P_DATA_WIDTH  write data (ignored on read)
- cmd_wstrb  in  P_DATA_WIDTH/8  write strobes (ignored on read)
- rsp_valid / rsp_ready  out / in  1  response handshake
- rsp_write  out  1  echo of cmd_write
- rsp_rdata  out  P_DATA_WIDTH  read data; 0 for writes and timeouts
- rsp_resp  out  2  BRESP/RRESP; 2'b10 on timeout
- rsp_timeout  out  1  response generated by timeout
- m_axi_awaddr/awprot/awvalid/awready, m_axi_wdata/wstrb/wvalid/wready, m_axi_bresp/bvalid/bready, m_axi_araddr/arprot/arvalid/arready, m_axi_rdata/rresp/rvalid/rready  standard AXI4-Lite master ports, widths per parameters

## Operation
- States: IDLE, WR (AW+W), WR_B, RD_AR, RD_R, RSP, DRAIN.
- IDLE: cmd_ready=1. On cmd handshake, the block latches all cmd fields and moves to WR or RD_AR. The timeout counter is cleared.
- WR: awvalid and wvalid rise together. Each drops independently on its own handshake. A simultaneous or early awready/wready is recorded in per-channel done flags. Once both flags are set, go to WR_B.
- WR_B: bready=1. On the B handshake, capture bresp and go to RSP.
- RD_AR: arvalid=1 until the AR handshake, then go to RD_R.
- RD_R: rready=1. On the R handshake, capture rdata/rresp and go to RSP.
- RSP: rsp_valid=1 and fields are held stable until rsp_ready, then go to IDLE. The response registers are not overwritten while rsp_valid=1.
- awprot=arprot=3'b000 always. The address, data and strobe outputs are held stable while their valid is high.
- Timeout:
  - The counter increments each cycle in WR, WR_B, RD_AR and RD_R.
  - On reaching P_TIMEOUT_CYCLES, the block emits a response with rsp_timeout=1, rsp_resp=2'b10 and rsp_rdata=0, then enters DRAIN.
  - DRAIN keeps any pending valid asserted, since VALID is never withdrawn. It keeps bready/rready=1 and completes the outstanding handshakes, discarding the late B/R.
  - DRAIN returns to IDLE only when the transaction is fully retired and the timeout response has been accepted. cmd_ready=0 throughout.
- Counter width is clog2(P_TIMEOUT_CYCLES+1). The counter saturates and does not wrap.

## Timing
- Reset values: all valid and ready outputs 0 except cmd_ready=1; all address, data, strobe, resp and rdata outputs 0; rsp_timeout=0; state IDLE; counter 0.
- Reset mid-transaction aborts immediately to the reset values. The slave is reset by the same ARESETn.
- All outputs are registered. cmd_ready and all AXI valid/ready outputs have no combinational path from any input.
- Command handshake at edge N: awvalid/wvalid (or arvalid) are high from cycle N+1.
- Zero-wait slave write: AW/W handshake in cycle N+1; bready high from N+2.
- rsp_valid rises the cycle after the B or R handshake edge.
- Back-to-back commands: cmd_ready returns high the cycle after the rsp handshake. Minimum command-to-command spacing is therefore 5 cycles for a write with a zero-wait slave.
- Timeout is counted from cycle N+1. rsp_valid for a timeout rises at N+1+P_TIMEOUT_CYCLES.

## Test plan
- Write 0x00000006 to addr 0x4, wstrb 4'hF, with the UART slave attached.
  - Expect one AW and one W carrying those values.
  - Expect a response with rsp_write=1, rsp_resp=2'b00, rsp_timeout=0.
- Read addr 0x0 after the loopback frame is received (tx tied to rx).
  - Expect one AR at 0x0 and a response with rsp_rdata=0x6 and rsp_resp=2'b00.
- Slave model asserts wready 3 cycles before awready.
  - Expect wvalid to drop after its own handshake while awvalid stays high.
  - Expect bready only after both handshakes, and exactly one B accepted.
- rsp_ready held low for 10 cycles after rsp_valid.
  - Expect the response stable for those 10 cycles and cmd_ready=0.
  - Expect the next command accepted the cycle after the response is consumed.
- P_TIMEOUT_CYCLES=16 with a slave that never asserts arready.
  - Expect rsp_timeout=1, rsp_resp=2'b10 at cycle 17 after the command, and arvalid still high.
  - Later, arready then rvalid: expect both handshakes to complete, no second response, and a return to IDLE.
- ARESETn pulsed low while in WR_B.
  - Expect all outputs at reset values asynchronously, cmd_ready=1 after release, and no response emitted.
